// File: rtl/reg_scoreboard_pkg.sv
// rtl/reg_scoreboard_pkg.sv - shared constants for the register scoreboard
package reg_scoreboard_pkg;

  // Architectural register index width and the hard-wired zero register
  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;

  // Default per-register outstanding-write counter width
  localparam int SB_CNT_W = 2;

endpackage

// File: rtl/reg_scoreboard_if.sv
// rtl/reg_scoreboard_if.sv - issue/retire/flush bundle between pipeline stages and the scoreboard
interface reg_scoreboard_if
  import reg_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = 2 ** REG_IDX_W,
  parameter int CNT_W    = SB_CNT_W
);
  localparam int REG_W = $clog2(NUM_REGS);

  logic                   flush;
  logic                   issue_valid;
  logic                   issue_rd_en;
  logic [REG_W-1:0]       issue_rd;
  logic                   issue_rs1_en;
  logic [REG_W-1:0]       issue_rs1;
  logic                   issue_rs2_en;
  logic [REG_W-1:0]       issue_rs2;
  logic                   issue_ready;
  logic                   retire_valid;
  logic [REG_W-1:0]       retire_rd;
  logic [NUM_REGS-1:0]    busy_mask;
  logic [REG_W+CNT_W-1:0] inflight_cnt;
  logic                   err_underflow;

  // Pipeline side: drives issue, retire and flush; observes hazard state
  modport master (
    output flush, issue_valid, issue_rd_en, issue_rd,
           issue_rs1_en, issue_rs1, issue_rs2_en, issue_rs2,
           retire_valid, retire_rd,
    input  issue_ready, busy_mask, inflight_cnt, err_underflow
  );

  // Scoreboard side
  modport slave (
    input  flush, issue_valid, issue_rd_en, issue_rd,
           issue_rs1_en, issue_rs1, issue_rs2_en, issue_rs2,
           retire_valid, retire_rd,
    output issue_ready, busy_mask, inflight_cnt, err_underflow
  );
endinterface

// File: rtl/reg_scoreboard_sb_counter.sv
// rtl/reg_scoreboard_sb_counter.sv - saturating up/down counter of outstanding writes to one register
module sb_counter
  import reg_scoreboard_pkg::*;
#(
  parameter int CNT_W = SB_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero,
  output logic             sat,
  output logic             underflow
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  assign zero      = (count == '0);
  assign sat       = (count == CNT_MAX);
  // A lone retire against an empty counter; a same-cycle issue cancels it out
  assign underflow = dec && !inc && zero;

  // Clear wins; simultaneous inc/dec cancel; the count never wraps in either direction
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && !dec && !sat) begin
      count <= count + CNT_W'(1);
    end else if (dec && !inc && !zero) begin
      count <= count - CNT_W'(1);
    end
  end
endmodule

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register in-flight write scoreboard with hazard detection
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int NUM_REGS      = 2 ** REG_IDX_W,
  parameter int CNT_W         = SB_CNT_W,
  parameter int BYPASS_RETIRE = 1
) (
  input  logic             clk,
  input  logic             reset,
  reg_scoreboard_if.slave  sb
);
  localparam int REG_W = $clog2(NUM_REGS);
  localparam int TOT_W = REG_W + CNT_W;
  localparam logic [REG_W-1:0] RZERO = REG_W'(REG_ZERO);

  logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
  logic [NUM_REGS-1:0]            zero_v;
  logic [NUM_REGS-1:0]            sat_v;
  logic [NUM_REGS-1:1]            inc_v;
  logic [NUM_REGS-1:1]            dec_v;
  logic [NUM_REGS-1:1]            underflow_v;

  logic [CNT_W-1:0] rs1_cnt;
  logic [CNT_W-1:0] rs2_cnt;
  logic             rs1_busy;
  logic             rs2_busy;
  logic             rd_sat;
  logic             ready;
  logic             acc_trk;
  logic             ret_ok;
  logic             underflow_any;
  logic [TOT_W-1:0] inflight_q;
  logic             err_q;

  // Register 0 is never tracked: permanently idle, never saturated
  assign cnt[0]    = '0;
  assign zero_v[0] = 1'b1;
  assign sat_v[0]  = 1'b0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_cnt
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk       (clk),
      .reset     (reset),
      .clr       (sb.flush),
      .inc       (inc_v[i]),
      .dec       (dec_v[i]),
      .count     (cnt[i]),
      .zero      (zero_v[i]),
      .sat       (sat_v[i]),
      .underflow (underflow_v[i])
    );
  end

  // Source hazards; a source whose last outstanding write retires this cycle may bypass
  always_comb begin
    rs1_cnt  = cnt[sb.issue_rs1];
    rs2_cnt  = cnt[sb.issue_rs2];
    rs1_busy = sb.issue_rs1_en && (sb.issue_rs1 != RZERO) && (rs1_cnt != '0)
               && !((BYPASS_RETIRE != 0) && sb.retire_valid
                    && (sb.retire_rd == sb.issue_rs1) && (rs1_cnt == CNT_W'(1)));
    rs2_busy = sb.issue_rs2_en && (sb.issue_rs2 != RZERO) && (rs2_cnt != '0)
               && !((BYPASS_RETIRE != 0) && sb.retire_valid
                    && (sb.retire_rd == sb.issue_rs2) && (rs2_cnt == CNT_W'(1)));
    rd_sat   = sb.issue_rd_en && (sb.issue_rd != RZERO) && sat_v[sb.issue_rd];
    ready    = !sb.flush && !rs1_busy && !rs2_busy && !rd_sat;
    acc_trk  = sb.issue_valid && ready && sb.issue_rd_en && (sb.issue_rd != RZERO);
  end

  // Decode accepted destination and retiring register into per-counter strobes
  always_comb begin
    inc_v = '0;
    dec_v = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      inc_v[i] = acc_trk && (sb.issue_rd == REG_W'(i));
      dec_v[i] = sb.retire_valid && (sb.retire_rd == REG_W'(i));
    end
  end

  assign underflow_any = |underflow_v;
  assign ret_ok        = sb.retire_valid && (sb.retire_rd != RZERO) && !underflow_any;

  // Running total of tracked outstanding writes, kept in step with the counters
  always_ff @(posedge clk) begin
    if (reset || sb.flush) begin
      inflight_q <= '0;
    end else begin
      case ({acc_trk, ret_ok})
        2'b10:   inflight_q <= inflight_q + TOT_W'(1);
        2'b01:   inflight_q <= inflight_q - TOT_W'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  // Sticky underflow flag; a flushed retire is discarded and cannot set it
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (!sb.flush && underflow_any) begin
      err_q <= 1'b1;
    end
  end

  assign sb.issue_ready   = ready;
  assign sb.busy_mask     = ~zero_v;
  assign sb.inflight_cnt  = inflight_q;
  assign sb.err_underflow = err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - scoreboard-checked directed bench for reg_scoreboard
module tb_reg_scoreboard;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       flush = 0, iv = 0, rd_en = 0, rs1_en = 0, rs2_en = 0, rv = 0;
  logic [4:0] rd = 0, rs1 = 0, rs2 = 0, rrd = 0;

  reg_scoreboard_if #(.NUM_REGS(32), .CNT_W(2)) if1 ();
  reg_scoreboard_if #(.NUM_REGS(32), .CNT_W(2)) if0 ();

  assign if1.flush = flush;        assign if0.flush = flush;
  assign if1.issue_valid = iv;     assign if0.issue_valid = iv;
  assign if1.issue_rd_en = rd_en;  assign if0.issue_rd_en = rd_en;
  assign if1.issue_rd = rd;        assign if0.issue_rd = rd;
  assign if1.issue_rs1_en = rs1_en; assign if0.issue_rs1_en = rs1_en;
  assign if1.issue_rs1 = rs1;      assign if0.issue_rs1 = rs1;
  assign if1.issue_rs2_en = rs2_en; assign if0.issue_rs2_en = rs2_en;
  assign if1.issue_rs2 = rs2;      assign if0.issue_rs2 = rs2;
  assign if1.retire_valid = rv;    assign if0.retire_valid = rv;
  assign if1.retire_rd = rrd;      assign if0.retire_rd = rrd;

  reg_scoreboard #(.NUM_REGS(32), .CNT_W(2), .BYPASS_RETIRE(1)) dut1 (
    .clk(clk), .reset(reset), .sb(if1)
  );
  reg_scoreboard #(.NUM_REGS(32), .CNT_W(2), .BYPASS_RETIRE(0)) dut0 (
    .clk(clk), .reset(reset), .sb(if0)
  );

  typedef struct {
    string       tag;
    logic        rdy1;
    logic        rdy0;
    logic [31:0] mask;
    logic [6:0]  cnt;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s actual=0x%0h required=0x%0h", tag, nm, act, req);
    end
  endtask

  // Monitor: pops one expectation per cycle and compares both DUTs mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.tag, "ready_byp1", 32'(if1.issue_ready), 32'(e.rdy1));
      chk(e.tag, "ready_byp0", 32'(if0.issue_ready), 32'(e.rdy0));
      chk(e.tag, "busy_mask", if1.busy_mask, e.mask);
      chk(e.tag, "inflight", 32'(if1.inflight_cnt), 32'(e.cnt));
      chk(e.tag, "err", 32'(if1.err_underflow), 32'(e.err));
      chk(e.tag, "busy_mask_b0", if0.busy_mask, e.mask);
      chk(e.tag, "inflight_b0", 32'(if0.inflight_cnt), 32'(e.cnt));
    end
  end

  // Driver: apply one cycle of stimulus and queue the hand-computed expectation
  task automatic cyc(input string tag, input logic rst, input logic fl,
                     input logic v, input logic de, input logic [4:0] d,
                     input logic s1e, input logic [4:0] s1,
                     input logic s2e, input logic [4:0] s2,
                     input logic re, input logic [4:0] r,
                     input logic e1, input logic e0, input logic [31:0] m,
                     input logic [6:0] c, input logic er);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; flush = fl; iv = v; rd_en = de; rd = d;
    rs1_en = s1e; rs1 = s1; rs2_en = s2e; rs2 = s2; rv = re; rrd = r;
    e.tag = tag; e.rdy1 = e1; e.rdy0 = e0; e.mask = m; e.cnt = c; e.err = er;
    exp_q.push_back(e);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    //  tag          rst fl iv de rd  1e rs1 2e rs2 rv rrd  r1 r0 mask          cnt er
    cyc("reset",     0, 0, 0, 0, 0,  0, 0,  0, 0,  0, 0,   1, 1, 32'h0,        0, 0);
    cyc("iss5",      0, 0, 1, 1, 5,  0, 0,  0, 0,  0, 0,   1, 1, 32'h0,        0, 0);
    cyc("haz5",      0, 0, 0, 0, 0,  1, 5,  0, 0,  0, 0,   0, 0, 32'h20,       1, 0);
    cyc("byp5",      0, 0, 0, 0, 0,  1, 5,  0, 0,  1, 5,   1, 0, 32'h20,       1, 0);
    cyc("post5",     0, 0, 0, 0, 0,  1, 5,  0, 0,  0, 0,   1, 1, 32'h0,        0, 0);
    cyc("iss7a",     0, 0, 1, 1, 7,  0, 0,  0, 0,  0, 0,   1, 1, 32'h0,        0, 0);
    cyc("iss7b",     0, 0, 1, 1, 7,  0, 0,  0, 0,  0, 0,   1, 1, 32'h80,       1, 0);
    cyc("iss7c",     0, 0, 1, 1, 7,  0, 0,  0, 0,  0, 0,   1, 1, 32'h80,       2, 0);
    cyc("sat7",      0, 0, 1, 1, 7,  0, 0,  0, 0,  0, 0,   0, 0, 32'h80,       3, 0);
    cyc("sat7ret",   0, 0, 1, 1, 7,  0, 0,  0, 0,  1, 7,   0, 0, 32'h80,       3, 0);
    cyc("unsat7",    0, 0, 0, 1, 7,  0, 0,  0, 0,  0, 0,   1, 1, 32'h80,       2, 0);
    cyc("iss9",      0, 0, 1, 1, 9,  0, 0,  0, 0,  0, 0,   1, 1, 32'h80,       2, 0);
    cyc("issret9",   0, 0, 1, 1, 9,  0, 0,  0, 0,  1, 9,   1, 1, 32'h280,      3, 0);
    cyc("hold9",     0, 0, 0, 0, 0,  0, 0,  0, 0,  0, 0,   1, 1, 32'h280,      3, 0);
    cyc("iss1",      0, 0, 1, 1, 1,  0, 0,  0, 0,  0, 0,   1, 1, 32'h280,      3, 0);
    cyc("iss2",      0, 0, 1, 1, 2,  0, 0,  0, 0,  0, 0,   1, 1, 32'h282,      4, 0);
    cyc("iss3",      0, 0, 1, 1, 3,  0, 0,  0, 0,  0, 0,   1, 1, 32'h286,      5, 0);
    cyc("flush",     0, 1, 1, 1, 4,  0, 0,  0, 0,  1, 7,   0, 0, 32'h28e,      6, 0);
    cyc("postflush", 0, 0, 0, 0, 0,  0, 0,  0, 0,  0, 0,   1, 1, 32'h0,        0, 0);
    cyc("uflow4",    0, 0, 0, 0, 0,  0, 0,  0, 0,  1, 4,   1, 1, 32'h0,        0, 0);
    cyc("errset",    0, 0, 0, 0, 0,  0, 0,  0, 0,  0, 0,   1, 1, 32'h0,        0, 1);
    cyc("flush2",    0, 1, 0, 0, 0,  0, 0,  0, 0,  0, 0,   0, 0, 32'h0,        0, 1);
    cyc("reg0",      0, 0, 1, 1, 0,  0, 0,  0, 0,  1, 0,   1, 1, 32'h0,        0, 1);
    cyc("postreg0",  0, 0, 0, 0, 0,  0, 0,  0, 0,  0, 0,   1, 1, 32'h0,        0, 1);
    cyc("iss6",      0, 0, 1, 1, 6,  0, 0,  0, 0,  0, 0,   1, 1, 32'h0,        0, 1);
    cyc("haz6rs2",   0, 0, 0, 0, 0,  0, 6,  1, 6,  0, 0,   0, 0, 32'h40,       1, 1);
    cyc("rstmid",    1, 0, 0, 0, 0,  0, 0,  0, 0,  0, 0,   1, 1, 32'h40,       1, 1);
    cyc("postrst",   0, 0, 0, 0, 0,  0, 0,  0, 0,  0, 0,   1, 1, 32'h0,        0, 0);
    @(posedge clk);
    #1;
    iv = 0; rv = 0; flush = 0;
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
